// File: rtl/msrh_l2_port_responder.sv
// L2-side responder: arbitrates three tile request channels onto one memory
// channel (tag prefixed with port id) and routes memory responses back by id.

package msrh_l2_port_responder_pkg;
   typedef enum logic [1:0] {
      MEM_CMD_RD   = 2'd0,
      MEM_CMD_WR   = 2'd1,
      MEM_CMD_RDX  = 2'd2,
      MEM_CMD_ATOM = 2'd3
   } mem_cmd_t;
endpackage

module msrh_l2_port_responder
   import msrh_l2_port_responder_pkg::*;
#(
   parameter int unsigned ADDR_W   = 56,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned DATA_W   = 256,
   parameter int unsigned MAX_OUTS = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [2:0]                    i_req_valid,
   input  mem_cmd_t [2:0]                i_req_cmd,
   input  logic [2:0][ADDR_W-1:0]        i_req_addr,
   input  logic [2:0][TAG_W-1:0]         i_req_tag,
   input  logic [2:0][DATA_W-1:0]        i_req_data,
   input  logic [2:0][DATA_W/8-1:0]      i_req_byte_en,
   output logic [2:0]                    o_req_ready,
   output logic [2:0]                    o_resp_valid,
   output logic [TAG_W-1:0]              o_resp_tag,
   output logic [DATA_W-1:0]             o_resp_data,
   input  logic [2:0]                    i_resp_ready,
   output logic                          o_mem_req_valid,
   output mem_cmd_t                      o_mem_req_cmd,
   output logic [ADDR_W-1:0]             o_mem_req_addr,
   output logic [TAG_W+1:0]              o_mem_req_tag,
   output logic [DATA_W-1:0]             o_mem_req_data,
   output logic [DATA_W/8-1:0]           o_mem_req_byte_en,
   input  logic                          i_mem_req_ready,
   input  logic                          i_mem_resp_valid,
   input  logic [TAG_W+1:0]              i_mem_resp_tag,
   input  logic [DATA_W-1:0]             i_mem_resp_data,
   output logic                          o_mem_resp_ready,
   output logic                          o_err_bad_port
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

   logic [1:0]            rr_ptr;
   logic [2:0][CNT_W-1:0] outs_cnt;
   logic [2:0]            eligible;
   logic                  grant_found;
   logic [1:0]            grant_id;
   logic [1:0]            cand;
   logic                  slot_free;
   logic                  grant_en;
   logic [2:0]            cnt_inc;
   logic [2:0]            cnt_dec;
   logic                  resp_hs;
   logic                  mem_resp_acc;
   logic [1:0]            resp_id;

   // (base + off) mod 3 for port indices 0..2
   function automatic logic [1:0] port_add(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   // Round-robin grant among ports with a request and spare outstanding credit
   always_comb begin
      grant_found = 1'b0;
      grant_id    = 2'd0;
      cand        = 2'd0;
      for (int p = 0; p < 3; p++) begin
         eligible[p] = i_req_valid[p] && (outs_cnt[p] < CNT_MAX);
      end
      for (int off = 0; off < 3; off++) begin
         cand = port_add(rr_ptr, 2'(off));
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   // Handshake qualifiers shared by the request, response and credit logic
   always_comb begin
      slot_free        = !o_mem_req_valid || i_mem_req_ready;
      grant_en         = slot_free && grant_found && !i_reset;
      o_req_ready      = grant_en ? (3'b001 << grant_id) : 3'b000;
      cnt_inc          = o_req_ready;
      cnt_dec          = o_resp_valid & i_resp_ready;
      resp_hs          = |cnt_dec;
      o_mem_resp_ready = !i_reset && (!(|o_resp_valid) || resp_hs);
      mem_resp_acc     = i_mem_resp_valid && o_mem_resp_ready;
      resp_id          = i_mem_resp_tag[TAG_W+1:TAG_W];
   end

   // Downstream request register and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_mem_req_valid   <= 1'b0;
         o_mem_req_cmd     <= MEM_CMD_RD;
         o_mem_req_addr    <= '0;
         o_mem_req_tag     <= '0;
         o_mem_req_data    <= '0;
         o_mem_req_byte_en <= '0;
         rr_ptr            <= 2'd0;
      end else if (grant_en) begin
         o_mem_req_valid   <= 1'b1;
         o_mem_req_cmd     <= i_req_cmd[grant_id];
         o_mem_req_addr    <= i_req_addr[grant_id];
         o_mem_req_tag     <= {grant_id, i_req_tag[grant_id]};
         o_mem_req_data    <= i_req_data[grant_id];
         o_mem_req_byte_en <= i_req_byte_en[grant_id];
         rr_ptr            <= port_add(grant_id, 2'd1);
      end else if (i_mem_req_ready) begin
         o_mem_req_valid   <= 1'b0;
      end
   end

   // Per-port outstanding credit: up on grant, down on response delivery
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         outs_cnt <= '0;
      end else begin
         for (int p = 0; p < 3; p++) begin
            if (cnt_inc[p] && !cnt_dec[p] && (outs_cnt[p] != CNT_MAX)) begin
               outs_cnt[p] <= outs_cnt[p] + CNT_W'(1);
            end else if (!cnt_inc[p] && cnt_dec[p] && (outs_cnt[p] != '0)) begin
               outs_cnt[p] <= outs_cnt[p] - CNT_W'(1);
            end
         end
      end
   end

   // Response register routed by port id; id 3 is dropped and flagged
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_resp_valid   <= 3'b000;
         o_resp_tag     <= '0;
         o_resp_data    <= '0;
         o_err_bad_port <= 1'b0;
      end else begin
         if (mem_resp_acc && (resp_id == 2'd3)) begin
            o_err_bad_port <= 1'b1;
         end
         if (mem_resp_acc && (resp_id != 2'd3)) begin
            o_resp_valid <= 3'b001 << resp_id;
            o_resp_tag   <= i_mem_resp_tag[TAG_W-1:0];
            o_resp_data  <= i_mem_resp_data;
         end else if (resp_hs) begin
            o_resp_valid <= 3'b000;
         end
      end
   end

endmodule

// File: tb/tb_msrh_l2_port_responder.sv
// Randomized scoreboard bench for msrh_l2_port_responder.
module tb_msrh_l2_port_responder;
   import msrh_l2_port_responder_pkg::*;

   localparam int unsigned ADDR_W   = 56;
   localparam int unsigned TAG_W    = 4;
   localparam int unsigned DATA_W   = 256;
   localparam int unsigned BE_W     = DATA_W / 8;
   localparam int unsigned MAX_OUTS = 4;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [2:0]               req_valid = '0;
   mem_cmd_t [2:0]           req_cmd;
   logic [2:0][ADDR_W-1:0]   req_addr = '0;
   logic [2:0][TAG_W-1:0]    req_tag = '0;
   logic [2:0][DATA_W-1:0]   req_data = '0;
   logic [2:0][BE_W-1:0]     req_be = '0;
   logic [2:0]               req_ready;
   logic [2:0]               resp_valid;
   logic [TAG_W-1:0]         resp_tag;
   logic [DATA_W-1:0]        resp_data;
   logic [2:0]               resp_ready = '0;
   logic                     mreq_valid;
   mem_cmd_t                 mreq_cmd;
   logic [ADDR_W-1:0]        mreq_addr;
   logic [TAG_W+1:0]         mreq_tag;
   logic [DATA_W-1:0]        mreq_data;
   logic [BE_W-1:0]          mreq_be;
   logic                     mreq_ready = 1'b0;
   logic                     mresp_valid = 1'b0;
   logic [TAG_W+1:0]         mresp_tag = '0;
   logic [DATA_W-1:0]        mresp_data = '0;
   logic                     mresp_ready;
   logic                     err_bad_port;

   always #5 clk = ~clk;

   msrh_l2_port_responder #(
      .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .MAX_OUTS(MAX_OUTS)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(req_valid), .i_req_cmd(req_cmd), .i_req_addr(req_addr),
      .i_req_tag(req_tag), .i_req_data(req_data), .i_req_byte_en(req_be),
      .o_req_ready(req_ready),
      .o_resp_valid(resp_valid), .o_resp_tag(resp_tag), .o_resp_data(resp_data),
      .i_resp_ready(resp_ready),
      .o_mem_req_valid(mreq_valid), .o_mem_req_cmd(mreq_cmd), .o_mem_req_addr(mreq_addr),
      .o_mem_req_tag(mreq_tag), .o_mem_req_data(mreq_data), .o_mem_req_byte_en(mreq_be),
      .i_mem_req_ready(mreq_ready),
      .i_mem_resp_valid(mresp_valid), .i_mem_resp_tag(mresp_tag), .i_mem_resp_data(mresp_data),
      .o_mem_resp_ready(mresp_ready),
      .o_err_bad_port(err_bad_port)
   );

   typedef struct {
      mem_cmd_t          cmd;
      logic [ADDR_W-1:0] addr;
      logic [TAG_W+1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } mreq_t;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } resp_t;

   // scoreboard queues
   mreq_t            exp_mreq_q[$];
   resp_t            exp_resp_q[3][$];
   logic [TAG_W+1:0] mem_pend_q[$];

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   int    m_ptr;
   int    m_cnt[3];
   bit    m_slot_valid;
   mreq_t m_slot;
   bit    m_resp_valid;
   int    m_resp_port;
   bit    m_err;

   // pending per-port requests held by the bench until granted
   bit                have_req[3];
   mem_cmd_t          r_cmd[3];
   logic [ADDR_W-1:0] r_addr[3];
   logic [TAG_W-1:0]  r_tag[3];
   logic [DATA_W-1:0] r_data[3];
   logic [BE_W-1:0]   r_be[3];

   // memory-side response presenter
   bit                pres_valid;
   logic [TAG_W+1:0]  pres_tag;
   logic [DATA_W-1:0] pres_data;

   // phase knobs (percent probabilities)
   int       pr_req, pr_mrdy, pr_rrdy, pr_mresp, pr_bad;
   logic [2:0] mask;
   bit       rst_phase;
   bit       force_t1;
   int       rst_cnt;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < int'(DATA_W / 32); i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      for (int p = 0; p < 3; p++) begin
         m_cnt[p] = 0;
         exp_resp_q[p].delete();
      end
      m_slot_valid = 0;
      m_resp_valid = 0;
      m_resp_port  = 0;
      m_err        = 0;
      exp_mreq_q.delete();
      mem_pend_q.delete();
      pres_valid = 0;
   endtask

   // one clock of stimulus, model prediction and cycle-level checks
   task automatic run_cycle();
      bit         found;
      int         g;
      bit         resp_hs;
      bit         exp_mrr;
      logic [2:0] exp_rdy;
      logic [2:0] exp_rv;
      int         id;
      mreq_t      e;
      resp_t      r;

      @(posedge clk); #1;
      rst = rst_phase;
      for (int p = 0; p < 3; p++) begin
         if (!have_req[p] && mask[p] && pct(pr_req)) begin
            have_req[p] = 1;
            r_cmd[p]  = mem_cmd_t'(2'($urandom_range(3)));
            r_addr[p] = ADDR_W'({$urandom, $urandom});
            r_tag[p]  = TAG_W'($urandom);
            r_data[p] = rand_data();
            r_be[p]   = BE_W'($urandom);
            if (force_t1 && p == 0) begin
               r_tag[p]  = TAG_W'(5);
               r_addr[p] = ADDR_W'(32'h1000);
               force_t1  = 0;
            end
         end
         req_valid[p] = have_req[p];
         req_cmd[p]   = r_cmd[p];
         req_addr[p]  = r_addr[p];
         req_tag[p]   = r_tag[p];
         req_data[p]  = r_data[p];
         req_be[p]    = r_be[p];
         resp_ready[p] = !rst_phase && pct(pr_rrdy);
      end
      mreq_ready = !rst_phase && pct(pr_mrdy);
      if (!pres_valid && !rst_phase) begin
         if (pct(pr_bad)) begin
            pres_valid = 1;
            pres_tag   = {2'b11, TAG_W'($urandom)};
            pres_data  = rand_data();
         end else if (mem_pend_q.size() > 0 && pct(pr_mresp)) begin
            pres_valid = 1;
            pres_tag   = mem_pend_q.pop_front();
            pres_data  = rand_data();
         end
      end
      mresp_valid = pres_valid;
      mresp_tag   = pres_valid ? pres_tag : '0;
      mresp_data  = pres_valid ? pres_data : '0;

      // prediction for this cycle
      found = 0;
      g = 0;
      if (!rst_phase && (!m_slot_valid || mreq_ready)) begin
         for (int off = 0; off < 3; off++) begin
            int c;
            c = (m_ptr + off) % 3;
            if (!found && have_req[c] && m_cnt[c] < int'(MAX_OUTS)) begin
               found = 1;
               g = c;
            end
         end
      end
      exp_rdy = found ? 3'(1 << g) : 3'b000;
      resp_hs = m_resp_valid && resp_ready[m_resp_port];
      exp_mrr = !rst_phase && (!m_resp_valid || resp_hs);
      exp_rv  = m_resp_valid ? 3'(1 << m_resp_port) : 3'b000;

      @(negedge clk);
      check("req_ready",      DATA_W'(req_ready),    DATA_W'(exp_rdy));
      check("mem_resp_ready", DATA_W'(mresp_ready),  DATA_W'(exp_mrr));
      check("mem_req_valid",  DATA_W'(mreq_valid),   DATA_W'(m_slot_valid));
      check("resp_valid",     DATA_W'(resp_valid),   DATA_W'(exp_rv));
      check("err_bad_port",   DATA_W'(err_bad_port), DATA_W'(m_err));
      if (rst_phase && rst_cnt > 0) begin
         check("rst_mem_req_addr", DATA_W'(mreq_addr), '0);
         check("rst_mem_req_tag",  DATA_W'(mreq_tag),  '0);
         check("rst_resp_data",    resp_data,          '0);
      end

      // advance model to the next cycle
      if (rst_phase) begin
         model_reset();
         rst_cnt++;
      end else begin
         rst_cnt = 0;
         if (m_slot_valid && mreq_ready) mem_pend_q.push_back(m_slot.tag);
         if (found) begin
            e.cmd  = r_cmd[g];
            e.addr = r_addr[g];
            e.tag  = {2'(g), r_tag[g]};
            e.data = r_data[g];
            e.be   = r_be[g];
            m_slot = e;
            m_slot_valid = 1;
            exp_mreq_q.push_back(e);
            m_ptr = (g + 1) % 3;
            m_cnt[g]++;
            have_req[g] = 0;
         end else if (mreq_ready) begin
            m_slot_valid = 0;
         end
         if (resp_hs) m_cnt[m_resp_port]--;
         if (pres_valid && exp_mrr) begin
            id = int'(pres_tag[TAG_W+1:TAG_W]);
            if (id == 3) begin
               m_err = 1;
               if (resp_hs) m_resp_valid = 0;
            end else begin
               r.tag  = pres_tag[TAG_W-1:0];
               r.data = pres_data;
               exp_resp_q[id].push_back(r);
               m_resp_valid = 1;
               m_resp_port  = id;
            end
            pres_valid = 0;
         end else if (resp_hs) begin
            m_resp_valid = 0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic set_phase(input logic [2:0] m, input int rq, input int mr, input int rr,
                            input int ms, input int bd);
      mask = m; pr_req = rq; pr_mrdy = mr; pr_rrdy = rr; pr_mresp = ms; pr_bad = bd;
   endtask

   // monitor: pop expectations whenever the DUT completes a handshake
   initial begin
      mreq_t e;
      resp_t r;
      forever begin
         @(negedge clk);
         if (mreq_valid && mreq_ready) begin
            if (exp_mreq_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL mem_req_unexpected: actual tag=%0h required none", mreq_tag);
            end else begin
               e = exp_mreq_q.pop_front();
               check("mem_req_cmd",  DATA_W'(mreq_cmd),  DATA_W'(e.cmd));
               check("mem_req_addr", DATA_W'(mreq_addr), DATA_W'(e.addr));
               check("mem_req_tag",  DATA_W'(mreq_tag),  DATA_W'(e.tag));
               check("mem_req_data", mreq_data,          e.data);
               check("mem_req_be",   DATA_W'(mreq_be),   DATA_W'(e.be));
            end
         end
         for (int p = 0; p < 3; p++) begin
            if (resp_valid[p] && resp_ready[p]) begin
               if (exp_resp_q[p].size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL resp_unexpected: actual port=%0d tag=%0h required none", p, resp_tag);
               end else begin
                  r = exp_resp_q[p].pop_front();
                  check("resp_tag",  DATA_W'(resp_tag), DATA_W'(r.tag));
                  check("resp_data", resp_data,         r.data);
               end
            end
         end
      end
   end

   initial begin
      for (int p = 0; p < 3; p++) begin
         have_req[p] = 0;
         r_cmd[p] = MEM_CMD_RD;
         r_addr[p] = '0; r_tag[p] = '0; r_data[p] = '0; r_be[p] = '0;
         req_cmd[p] = MEM_CMD_RD;
      end
      pres_tag = '0; pres_data = '0; rst_cnt = 0;
      model_reset();
      force_t1 = 1;

      // reset
      rst_phase = 1; set_phase(3'b000, 0, 100, 100, 100, 0); run(3);
      rst_phase = 0;
      // single IC request, then full-rate all-port traffic
      set_phase(3'b001, 100, 100, 100, 100, 0); run(3);
      set_phase(3'b111, 100, 100, 100, 100, 0); run(40);
      // L1D only with responses blocked: credit cap
      set_phase(3'b010, 100, 100, 0, 100, 0);   run(20);
      set_phase(3'b010, 100, 100, 100, 100, 0); run(10);
      // downstream stall
      set_phase(3'b111, 100, 0, 100, 100, 0);   run(6);
      set_phase(3'b111, 100, 100, 100, 100, 0); run(4);
      // random traffic with occasional bad-port responses
      set_phase(3'b111, 60, 70, 70, 60, 3);     run(600);
      // reset mid-transfer with valids high
      set_phase(3'b111, 100, 100, 50, 100, 0);  run(10);
      rst_phase = 1; run(2);
      rst_phase = 0;
      set_phase(3'b111, 50, 60, 60, 70, 2);     run(200);
      // drain
      set_phase(3'b000, 0, 100, 100, 100, 0);   run(80);

      check("drain_mem_req_q", DATA_W'(exp_mreq_q.size()), '0);
      for (int p = 0; p < 3; p++) begin
         check("drain_resp_q", DATA_W'(exp_resp_q[p].size()), '0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
